key_debounce: RTL

Input conditioner between the board's active-low push-buttons (mode, inc, alarm_off) and the DigitalClock control FSM. It synchronises each raw key, rejects contact bounce, and emits a clean level plus single-cycle press/release pulses per key. The time/alarm adjustment logic consumes only these pulses, never raw pins. A 20 ms physical press produces exactly one `key_press` pulse.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 149 ++++++++++++++
 rtl/key_debounce.sv | 64 ++++++
 3 files changed

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the DigitalClock key front end.
//   KEY_MODE / KEY_INC / KEY_ALARM_OFF : bit positions of the keys in key_n
//   db_state_t                         : per-key debounce FSM state
//   ms_to_cycles()                     : milliseconds -> clock cycles
// ---------------------------------------------------------------------------
package clock_pkg;

   localparam int KEY_MODE      = 0;
   localparam int KEY_INC       = 1;
   localparam int KEY_ALARM_OFF = 2;

   typedef enum logic [1:0] {
      DB_IDLE       = 2'd0,  // debounced released
      DB_PRESS_WAIT = 2'd1,  // raw low, waiting for it to stay low
      DB_HELD       = 2'd2,  // debounced pressed
      DB_REL_WAIT   = 2'd3   // raw high, waiting for it to stay high
   } db_state_t;

   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One key: two-flop synchroniser, 4-state debounce FSM, saturating stability
// counter and (with KEY_REPEAT_EN defined) an auto-repeat counter while held.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   key_n         : raw asynchronous key, 0 = pressed
//   level         : debounced state, 1 = pressed
//   press_pulse   : one-cycle pulse on debounced press (and on repeats)
//   release_pulse : one-cycle pulse on debounced release
//   state         : current FSM state (debug visibility)
// Optional feature macro: KEY_REPEAT_EN
// ---------------------------------------------------------------------------
module key_debounce_ch
   import clock_pkg::*;
#(
   parameter int DB_CYCLES = 20
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 20
`endif
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      key_n,
   output logic      level,
   output logic      press_pulse,
   output logic      release_pulse,
   output db_state_t state
);

   localparam int            CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync_meta;
   logic          sync_n;     // synchronised raw key, still active-low
   db_state_t     state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          level_nx;
   logic          press_nx;
   logic          release_nx;
   logic          rep_fire;

   // Synchroniser resets to "released" so reset never looks like a press edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b1;
         sync_n    <= 1'b1;
      end else begin
         sync_meta <= key_n;
         sync_n    <= sync_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= DB_IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         level         <= level_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
      end
   end

   // The counter only advances while below CNT_LAST; reaching it ends the
   // wait, so it saturates by construction and never wraps.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = level;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         DB_IDLE: begin
            if (!sync_n) begin
               state_nx = DB_PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         DB_PRESS_WAIT: begin
            if (sync_n) begin
               state_nx = DB_IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nx = DB_HELD;
               press_nx = 1'b1;
               level_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         DB_HELD: begin
            // A repeat due on the same cycle the key starts releasing still fires.
            press_nx = rep_fire;
            if (sync_n) begin
               state_nx = DB_REL_WAIT;
               cnt_nx   = '0;
            end
         end
         DB_REL_WAIT: begin
            if (!sync_n) begin
               state_nx = DB_HELD;
            end else if (cnt == CNT_LAST) begin
               state_nx   = DB_IDLE;
               release_nx = 1'b1;
               level_nx   = 1'b0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = DB_IDLE;
      endcase
   end

`ifdef KEY_REPEAT_EN
   localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int            RW         = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_first;  // next repeat uses the long initial delay

   assign rep_fire = (state == DB_HELD) &&
                     (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST));

   always_ff @(posedge clk) begin
      if (rst || (state != DB_HELD)) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_fire) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Conditions NUM_KEYS active-low push-buttons into clean debounced levels and
// single-cycle press/release pulses (bit 0 = mode, 1 = inc, 2 = alarm_off).
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   key_n       : raw asynchronous keys, 0 = pressed
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse per debounced press (and repeats if enabled)
//   key_release : one-cycle pulse per debounced release
//   key_state   : per-key FSM state, 2 bits per key (debug visibility)
// Optional feature macro: KEY_REPEAT_EN (auto-repeat of key_press while held)
// ---------------------------------------------------------------------------
module key_debounce
   import clock_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_MS     = 10,
   parameter int NUM_KEYS        = 3,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_KEYS-1:0]   key_n,
   output logic [NUM_KEYS-1:0]   key_level,
   output logic [NUM_KEYS-1:0]   key_press,
   output logic [NUM_KEYS-1:0]   key_release,
   output logic [2*NUM_KEYS-1:0] key_state
);

   localparam int DB_CYCLES    = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int REPEAT_DELAY = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
   localparam int REPEAT_RATE  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);

   // A zero-length window would make the counter compare against -1.
   if ((DB_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_cfg
      $error("key_debounce: timing parameters must give at least one cycle");
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      db_state_t ch_state;

      key_debounce_ch #(
         .DB_CYCLES    (DB_CYCLES)
`ifdef KEY_REPEAT_EN
         ,
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
`endif
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .key_n         (key_n[i]),
         .level         (key_level[i]),
         .press_pulse   (key_press[i]),
         .release_pulse (key_release[i]),
         .state         (ch_state)
      );

      assign key_state[2*i +: 2] = ch_state;
   end

endmodule
